div_issue_ctrl: RTL and testbench

// - Issue stage in front of the unsigned iterative divider (RV32M DIV/DIVU/REM/REMU).
// - Decodes funct3, filters divide-by-zero and signed overflow locally, and converts

---
 rtl/div_issue_ctrl_pkg.sv | 26 ++
 rtl/div_sign_fix.sv | 23 ++
 rtl/div_issue_ctrl.sv | 139 +++++++++++++
 tb/tb_div_issue_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// rtl/div_issue_ctrl_pkg.sv - shared M-extension divide definitions
package div_issue_ctrl_pkg;

  localparam int MEXT_XLEN = 32;
  localparam int MEXT_RLEN = 5;

  // funct3 encodings of the divide class (funct3[2] set)
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // Most negative value; also used by the multiplier stage for overflow cases
  localparam logic [MEXT_XLEN-1:0] MEXT_OVF_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FAST,
    ST_LAUNCH,
    ST_WAIT,
    ST_FIX,
    ST_DRAIN,
    ST_WB
  } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - operand magnitudes in, conditional negate out
module div_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic            signed_op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] fix_val,
  input  logic            fix_neg,
  output logic [XLEN-1:0] mag1,
  output logic [XLEN-1:0] mag2,
  output logic [XLEN-1:0] fix_out
);

  // Two's complement magnitude; the most negative value maps onto itself,
  // which is the correct unsigned magnitude for the divider
  always_comb begin
    mag1    = (signed_op && rs1[XLEN-1]) ? (~rs1 + 1'b1) : rs1;
    mag2    = (signed_op && rs2[XLEN-1]) ? (~rs2 + 1'b1) : rs2;
    fix_out = fix_neg ? (~fix_val + 1'b1) : fix_val;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - divide issue stage: decode, fast filter, divider handshake, write-back
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int XLEN = MEXT_XLEN,
  parameter int RLEN = MEXT_RLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [RLEN-1:0] rd_in,
  input  logic            flush,
  output logic            stall,
  output logic            div_reset,
  output logic            div_start,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic [XLEN-1:0] div_result,
  input  logic [XLEN-1:0] div_reminder,
  input  logic            div_done,
  input  logic            div_err,
  output logic            wb_valid,
  output logic [RLEN-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            fault
);

  localparam logic [XLEN-1:0] OVF_MIN = XLEN'(MEXT_OVF_MIN);

  div_state_e      state, state_n;
  logic [XLEN-1:0] dividend_q, divisor_q, raw_q, result_q;
  logic [RLEN-1:0] rd_q;
  logic            is_rem_q, neg_res_q, err_q, fault_q;

  logic            signed_op, is_rem, div_zero, ovf, accept, use_fast, in_divider;
  logic [XLEN-1:0] mag1, mag2, fix_out, fast_val;

  div_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .signed_op (signed_op),
    .rs1       (rs1_val),
    .rs2       (rs2_val),
    .fix_val   (raw_q),
    .fix_neg   (neg_res_q),
    .mag1      (mag1),
    .mag2      (mag2),
    .fix_out   (fix_out)
  );

  // Decode and the zero-divisor / signed-overflow filter evaluated at accept
  always_comb begin
    signed_op = ~funct3[0];
    is_rem    = funct3[1];
    div_zero  = (rs2_val == '0);
    ovf       = signed_op && (rs1_val == OVF_MIN) && (rs2_val == '1);
    use_fast  = div_zero || ovf;
    accept    = (state == ST_IDLE) && valid_in && funct3[2] && !flush;
    if (div_zero) fast_val = is_rem ? rs1_val : '1;
    else          fast_val = is_rem ? '0 : OVF_MIN;
  end

  // Next-state logic; flush from any active state returns to idle
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (accept) state_n = use_fast ? ST_FAST : ST_LAUNCH;
      ST_FAST:   state_n = ST_WB;
      ST_LAUNCH: state_n = ST_WAIT;
      ST_WAIT:   if (div_done) state_n = ST_FIX;
      ST_FIX:    state_n = ST_DRAIN;
      ST_DRAIN:  if (!div_done) state_n = ST_WB;
      ST_WB:     state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
    if (flush && state != ST_IDLE) state_n = ST_IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Operand capture at accept, result capture from the divider, sign fix-up
  always_ff @(posedge clk) begin
    if (reset) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      raw_q      <= '0;
      result_q   <= '0;
      rd_q       <= '0;
      is_rem_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      err_q      <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      if (accept) begin
        rd_q     <= rd_in;
        is_rem_q <= is_rem;
        err_q    <= 1'b0;
        if (use_fast) begin
          result_q <= fast_val;
        end else begin
          dividend_q <= mag1;
          divisor_q  <= mag2;
          neg_res_q  <= is_rem ? (signed_op && rs1_val[XLEN-1])
                               : (signed_op && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]));
        end
      end
      if (state == ST_WAIT && !flush) begin
        if (div_err) begin
          err_q   <= 1'b1;
          fault_q <= 1'b1;
        end
        if (div_done) raw_q <= is_rem_q ? div_reminder : div_result;
      end
      if (state == ST_FIX) result_q <= err_q ? '1 : fix_out;
    end
  end

  // Handshake and pipeline-control outputs; everything but div_reset is quiet in reset
  always_comb begin
    in_divider   = (state == ST_LAUNCH) || (state == ST_WAIT) ||
                   (state == ST_FIX)    || (state == ST_DRAIN);
    stall        = !reset && (((state != ST_IDLE) && (state != ST_WB)) ||
                              ((state == ST_IDLE) && valid_in && funct3[2]));
    div_reset    = reset || (flush && in_divider);
    div_start    = !reset && ((state == ST_LAUNCH) || (state == ST_WAIT));
    div_dividend = reset ? '0 : dividend_q;
    div_divisor  = reset ? '0 : divisor_q;
    wb_valid     = !reset && (state == ST_WB) && !flush;
    wb_rd        = reset ? '0 : rd_q;
    wb_data      = reset ? '0 : result_q;
    fault        = !reset && fault_q;
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed bench for div_issue_ctrl with a behavioural divider
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset, valid_in, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_in;
  logic        stall, div_reset, div_start, div_done, div_err;
  logic [31:0] div_dividend, div_divisor, div_result, div_reminder;
  logic        wb_valid, fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic inject_err = 1'b0;

  always #5 clk = ~clk;

  div_issue_ctrl dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush),
    .stall(stall), .div_reset(div_reset), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_result(div_result), .div_reminder(div_reminder),
    .div_done(div_done), .div_err(div_err),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault)
  );

  // Behavioural divider: done three start-cycles after launch, held until start drops
  int m_cnt = 0;
  always @(posedge clk) begin
    if (div_reset) begin
      div_done <= 1'b0; div_err <= 1'b0; m_cnt <= 0;
      div_result <= '0; div_reminder <= '0;
    end else if (div_start && !div_done) begin
      if (m_cnt == 2) begin
        div_done     <= 1'b1;
        div_err      <= inject_err;
        div_result   <= (div_divisor != 0) ? div_dividend / div_divisor : '1;
        div_reminder <= (div_divisor != 0) ? div_dividend % div_divisor : div_dividend;
        m_cnt        <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (!div_start) begin
      div_done <= 1'b0; div_err <= 1'b0; m_cnt <= 0;
    end
  end

  // Present one op, drop valid after accept, and observe until a few cycles past write-back
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] data, output logic [4:0] rdo,
                        output int lat, output int starts, output int wbs, output int early,
                        output logic [31:0] dvd, output logic [31:0] dvs);
    int cnt, after;
    logic prev_start, prev_done;
    data = 'x; rdo = 'x; dvd = 'x; dvs = 'x;
    lat = -1; starts = 0; wbs = 0; early = 0; cnt = 0; after = 0;
    prev_start = 1'b0; prev_done = 1'b0;
    @(negedge clk);
    valid_in = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b; rd_in = rd;
    while (cnt < 40 && after < 3) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) valid_in = 1'b0;
      if (div_start) begin
        starts++; dvd = div_dividend; dvs = div_divisor;
      end
      if (prev_start && !div_start && !prev_done) early++;
      prev_start = div_start; prev_done = div_done;
      if (wb_valid) begin
        wbs++;
        if (lat < 0) begin
          lat = cnt; data = wb_data; rdo = wb_rd;
        end
      end
      if (lat >= 0) after++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; valid_in = 1'b1; funct3 = 3'b100; rs1_val = 32'd1; rs2_val = 32'd1;
    rd_in = 5'd1; flush = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b want=0", stall); end
    n_cmp++; if (div_reset !== 1'b1) begin n_bad++; $display("FAIL reset_div_reset got=%b want=1", div_reset); end
    n_cmp++; if (div_start !== 1'b0) begin n_bad++; $display("FAIL reset_div_start got=%b want=0", div_start); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wb_valid got=%b want=0", wb_valid); end
    n_cmp++; if (wb_data !== 32'h0) begin n_bad++; $display("FAIL reset_wb_data got=%h want=0", wb_data); end
    n_cmp++; if (div_dividend !== 32'h0) begin n_bad++; $display("FAIL reset_dividend got=%h want=0", div_dividend); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got=%b want=0", fault); end
    reset = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    n_cmp++; if (div_reset !== 1'b0) begin n_bad++; $display("FAIL post_reset_div_reset got=%b want=0", div_reset); end
  endtask

  task automatic test_div_path;
    logic [31:0] d, dvd, dvs; logic [4:0] r; int lat, st, wbs, early;
    run_op(3'b100, 32'd12, 32'd3, 5'd5, d, r, lat, st, wbs, early, dvd, dvs);
    n_cmp++; if (d !== 32'd4) begin n_bad++; $display("FAIL div12_3_data got=%h want=4", d); end
    n_cmp++; if (r !== 5'd5) begin n_bad++; $display("FAIL div12_3_rd got=%0d want=5", r); end
    n_cmp++; if (wbs !== 1) begin n_bad++; $display("FAIL div12_3_wb_pulses got=%0d want=1", wbs); end
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL div12_3_latency got=%0d want=7", lat); end
    n_cmp++; if (st !== 4) begin n_bad++; $display("FAIL div12_3_start_cycles got=%0d want=4", st); end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL div12_3_start_early_drop got=%0d want=0", early); end
    n_cmp++; if (dvd !== 32'd12 || dvs !== 32'd3) begin n_bad++; $display("FAIL div12_3_operands got=%h/%h want=c/3", dvd, dvs); end
  endtask

  task automatic test_signed;
    logic [2:0]  f3 [4];
    logic [31:0] a [4];
    logic [31:0] exp [4];
    logic [31:0] d, dvd, dvs; logic [4:0] r; int lat, st, wbs, early;
    f3[0] = 3'b100; a[0] = 32'hFFFF_FFF9; exp[0] = 32'hFFFF_FFFD;
    f3[1] = 3'b110; a[1] = 32'hFFFF_FFF9; exp[1] = 32'hFFFF_FFFF;
    f3[2] = 3'b111; a[2] = 32'hFFFF_FFF9; exp[2] = 32'h0000_0001;
    f3[3] = 3'b101; a[3] = 32'hFFFF_FFF9; exp[3] = 32'h7FFF_FFFC;
    for (int i = 0; i < 4; i++) begin
      run_op(f3[i], a[i], 32'd2, 5'(i + 10), d, r, lat, st, wbs, early, dvd, dvs);
      n_cmp++; if (d !== exp[i]) begin n_bad++; $display("FAIL signed_%0d_data got=%h want=%h", i, d, exp[i]); end
      n_cmp++; if (r !== 5'(i + 10)) begin n_bad++; $display("FAIL signed_%0d_rd got=%0d want=%0d", i, r, i + 10); end
    end
    // DIV -7/2 must hand the divider magnitude 7
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3, d, r, lat, st, wbs, early, dvd, dvs);
    n_cmp++; if (dvd !== 32'd7) begin n_bad++; $display("FAIL signed_magnitude got=%h want=7", dvd); end
  endtask

  task automatic test_fast;
    logic [2:0]  f3 [4];
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] exp [4];
    logic [31:0] d, dvd, dvs; logic [4:0] r; int lat, st, wbs, early;
    f3[0] = 3'b101; a[0] = 32'd5;         b[0] = 32'd0;         exp[0] = 32'hFFFF_FFFF;
    f3[1] = 3'b110; a[1] = 32'd5;         b[1] = 32'd0;         exp[1] = 32'd5;
    f3[2] = 3'b100; a[2] = 32'h8000_0000; b[2] = 32'hFFFF_FFFF; exp[2] = 32'h8000_0000;
    f3[3] = 3'b110; a[3] = 32'h8000_0000; b[3] = 32'hFFFF_FFFF; exp[3] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      run_op(f3[i], a[i], b[i], 5'(i + 20), d, r, lat, st, wbs, early, dvd, dvs);
      n_cmp++; if (d !== exp[i]) begin n_bad++; $display("FAIL fast_%0d_data got=%h want=%h", i, d, exp[i]); end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL fast_%0d_latency got=%0d want=2", i, lat); end
      n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL fast_%0d_start_cycles got=%0d want=0", i, st); end
      n_cmp++; if (wbs !== 1) begin n_bad++; $display("FAIL fast_%0d_wb_pulses got=%0d want=1", i, wbs); end
    end
  endtask

  task automatic test_flush;
    logic [31:0] d, dvd, dvs; logic [4:0] r; int lat, st, wbs, early, wb_seen;
    @(negedge clk);
    valid_in = 1'b1; funct3 = 3'b101; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd9;
    @(negedge clk); valid_in = 1'b0;        // LAUNCH
    @(negedge clk);                         // WAIT
    n_cmp++; if (div_start !== 1'b1) begin n_bad++; $display("FAIL flush_pre_start got=%b want=1", div_start); end
    flush = 1'b1; #1;
    n_cmp++; if (div_reset !== 1'b1) begin n_bad++; $display("FAIL flush_div_reset got=%b want=1", div_reset); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL flush_stall_same got=%b want=1", stall); end
    @(negedge clk);
    flush = 1'b0; #1;
    n_cmp++; if (div_reset !== 1'b0) begin n_bad++; $display("FAIL flush_div_reset_pulse got=%b want=0", div_reset); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall_after got=%b want=0", stall); end
    wb_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wb_valid || div_start) wb_seen++;
    end
    n_cmp++; if (wb_seen !== 0) begin n_bad++; $display("FAIL flush_no_activity got=%0d want=0", wb_seen); end
    run_op(3'b101, 32'd9, 32'd4, 5'd6, d, r, lat, st, wbs, early, dvd, dvs);
    n_cmp++; if (d !== 32'd2) begin n_bad++; $display("FAIL flush_next_data got=%h want=2", d); end
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL flush_next_latency got=%0d want=7", lat); end
  endtask

  task automatic test_back_to_back;
    logic exp_stall [6];
    logic exp_wb [6];
    logic [31:0] exp_data [6];
    exp_stall[0] = 1; exp_stall[1] = 1; exp_stall[2] = 0;
    exp_stall[3] = 1; exp_stall[4] = 1; exp_stall[5] = 0;
    exp_wb[0] = 0; exp_wb[1] = 0; exp_wb[2] = 1; exp_wb[3] = 0; exp_wb[4] = 0; exp_wb[5] = 1;
    exp_data[2] = 32'hFFFF_FFFF; exp_data[5] = 32'd5;
    @(negedge clk);
    valid_in = 1'b1; funct3 = 3'b101; rs1_val = 32'd5; rs2_val = 32'd0; rd_in = 5'd1;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) begin
        funct3 = 3'b110; rd_in = 5'd2;
      end
      #1;
      n_cmp++; if (stall !== exp_stall[c]) begin n_bad++; $display("FAIL b2b_stall_c%0d got=%b want=%b", c, stall, exp_stall[c]); end
      n_cmp++; if (wb_valid !== exp_wb[c]) begin n_bad++; $display("FAIL b2b_wb_valid_c%0d got=%b want=%b", c, wb_valid, exp_wb[c]); end
      if (exp_wb[c]) begin
        n_cmp++; if (wb_data !== exp_data[c]) begin n_bad++; $display("FAIL b2b_data_c%0d got=%h want=%h", c, wb_data, exp_data[c]); end
      end
      @(negedge clk);
    end
    valid_in = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_end got=%b want=0", stall); end
  endtask

  task automatic test_fault_and_reset;
    logic [31:0] d, dvd, dvs; logic [4:0] r; int lat, st, wbs, early;
    inject_err = 1'b1;
    run_op(3'b101, 32'd10, 32'd2, 5'd7, d, r, lat, st, wbs, early, dvd, dvs);
    inject_err = 1'b0;
    n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL err_data got=%h want=ffffffff", d); end
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL err_fault got=%b want=1", fault); end
    run_op(3'b101, 32'd9, 32'd4, 5'd8, d, r, lat, st, wbs, early, dvd, dvs);
    n_cmp++; if (d !== 32'd2) begin n_bad++; $display("FAIL err_next_data got=%h want=2", d); end
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL err_fault_sticky got=%b want=1", fault); end
    // reset while waiting on the divider
    @(negedge clk);
    valid_in = 1'b1; funct3 = 3'b100; rs1_val = 32'd50; rs2_val = 32'd5; rd_in = 5'd4;
    @(negedge clk); valid_in = 1'b0;
    @(negedge clk);
    reset = 1'b1; #1;
    n_cmp++; if (div_reset !== 1'b1 || div_start !== 1'b0) begin n_bad++; $display("FAIL midop_reset got=%b/%b want=1/0", div_reset, div_start); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (fault !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL midop_reset_clear got=%b/%b want=0/0", fault, stall); end
    run_op(3'b100, 32'd50, 32'd5, 5'd4, d, r, lat, st, wbs, early, dvd, dvs);
    n_cmp++; if (d !== 32'd10 || lat !== 7) begin n_bad++; $display("FAIL midop_next got=%h lat=%0d want=a lat=7", d, lat); end
  endtask

  initial begin
    test_reset();
    test_div_path();
    test_signed();
    test_fast();
    test_flush();
    test_back_to_back();
    test_fault_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
